data_mem: RTL and testbench
===========================

# data_mem

Word-organised data memory for the single-cycle RISC-V core, sitting behind the load/store path of the execute/memory stage. It provides one synchronous write port with per-byte enables and one combinational read port gated by a read strobe. The read is combinational so that a load completes within the same core cycle.

## Interface
- MEM_SIZE, 256: depth in 32-bit words; must be a power of two, ≥ 2.
- ADDR_SIZE, $clog2(MEM_SIZE): word-index width; derived, not overridden.
- Clk_Core  input  1  core clock; all writes occur on its rising edge.
- Rst_Core_N  input  1  asynchronous, active-low reset.
- Read_Ctrl  input  1  read strobe; 1 drives the addressed word onto Mem_Data_Read.
- Write_Ctrl  input  4  byte write enables; bit j writes byte lane j (bits 8j+7:8j).
- Mem_Data_Address  input  32  byte address.
- Mem_Data_Write  input  32  store data, lane-aligned (byte j in bits 8j+7:8j).
- Mem_Data_Read  output  32  load data.

One clock; reset is asynchronous and active-low.

## Operation
- Storage: MEM_SIZE words × 32 bits.
- Word index = Mem_Data_Address[ADDR_SIZE+1:2].
  - Bits [1:0] are ignored; no misalignment fault is raised.
  - Bits [31:ADDR_SIZE+2] are ignored, so addresses alias modulo MEM_SIZE*4 (see Configuration for the exception).
- Write: on a rising edge of Clk_Core, for each j with Write_Ctrl[j]=1, mem[idx][8j+7:8j] ← Mem_Data_Write[8j+7:8j].
  - Lanes with a 0 enable keep their value.
  - Write_Ctrl=4'b0000 means no write.
  - A write does not require Read_Ctrl.
- Read: Mem_Data_Read = Read_Ctrl ? mem[idx] : 32'h0, combinational from Read_Ctrl, the address and the array contents.
- Sign/zero extension and lane shifting for LB/LH are done by the core, not here.
- Reset: asserting Rst_Core_N low clears every word to 0 immediately, regardless of the clock. Writes are blocked while reset is asserted.

## Timing
- Write latency: 1 edge. Data is visible on Mem_Data_Read (if Read_Ctrl=1) just after the edge that performs the write.
- Read latency: 0 cycles (combinational).
- Simultaneous read and write to the same word: before the edge the output shows old data; after the edge it shows new data. There is no write-through bypass.
- Reset values:
  - Mem_Data_Read = 0.
  - All memory words = 0.
- Reset asserted mid-cycle with a write pending: the write is lost and memory stays 0.
- Reset released: the first write occurs on the first rising edge with Rst_Core_N=1.

## Configuration
- DATA_MEM_RANGE_CHECK_EN defined:
  - An address with any bit of [31:ADDR_SIZE+2] set is out of range.
  - Writes to it are ignored.
  - Reads of it return 32'h0.
- Undefined: upper address bits are ignored and addresses alias as described above.

## Structure
- Package data_mem_pkg holds:
  - Default MEM_SIZE constant.
  - Byte-lane constants (4 lanes × 8 bits).
  - Function byte_mask(Write_Ctrl) → 32-bit mask, 8'hFF per enabled lane.
- One natural sub-module: data_mem_byte_lane, one 8-bit-wide storage column per lane, generated 4×.

## Test plan
- Reset, then Read_Ctrl=1 at address 0x00 and at 0x3FC → Mem_Data_Read=0x00000000.
- Write 0xDEADBEEF with Write_Ctrl=4'b1111 at 0x10, then read 0x10 → 0xDEADBEEF. Read with Read_Ctrl=0 → 0x00000000.
- Partial writes to 0x20 (initially 0):
  - Write 0x11223344 with Write_Ctrl=4'b0101, read → 0x00220044.
  - Then write 0xAABBCCDD with Write_Ctrl=4'b1000, read → 0xAA220044.
- Address bits [1:0] ignored: write 0xCAFEF00D at 0x43, read 0x40 → 0xCAFEF00D.
- Aliasing with macro undefined and MEM_SIZE=256: write 0x12345678 at 0x404, read 0x004 → 0x12345678. With DATA_MEM_RANGE_CHECK_EN defined, the same read of 0x004 → 0x00000000, and a read of 0x404 → 0x00000000.
- Random regression, 1000 iterations: random address, data and Write_Ctrl, then read back. Compare against a masked reference model; expect no mismatches. Also assert Rst_Core_N between edges after a write → all locations read 0.

Source files
------------

// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared constants and helpers for the core's data memory.
// Holds the default depth, the byte-lane geometry and the write-enable
// to bit-mask expansion used by the store path.
package data_mem_pkg;

  localparam int MEM_SIZE_DEFAULT = 256;
  localparam int LANE_NUM         = 4;
  localparam int LANE_WIDTH       = 8;
  localparam int WORD_WIDTH       = LANE_NUM * LANE_WIDTH;

  // Expand per-lane write enables into a word mask, 8'hFF per enabled lane.
  function automatic logic [WORD_WIDTH-1:0] byte_mask(input logic [LANE_NUM-1:0] write_ctrl);
    logic [WORD_WIDTH-1:0] mask;
    mask = '0;
    for (int j = 0; j < LANE_NUM; j++) begin
      mask[j*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{write_ctrl[j]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/data_mem_if.sv
// data_mem_if: load/store bus between the core's memory stage (master)
// and the data memory (slave). Clock and reset stay outside the bundle.
interface data_mem_if;
  import data_mem_pkg::*;

  logic                  Read_Ctrl;
  logic [LANE_NUM-1:0]   Write_Ctrl;
  logic [31:0]           Mem_Data_Address;
  logic [WORD_WIDTH-1:0] Mem_Data_Write;
  logic [WORD_WIDTH-1:0] Mem_Data_Read;

  modport master (
    output Read_Ctrl,
    output Write_Ctrl,
    output Mem_Data_Address,
    output Mem_Data_Write,
    input  Mem_Data_Read
  );

  modport slave (
    input  Read_Ctrl,
    input  Write_Ctrl,
    input  Mem_Data_Address,
    input  Mem_Data_Write,
    output Mem_Data_Read
  );

endinterface

// File: rtl/data_mem_byte_lane.sv
// data_mem_byte_lane: one 8-bit storage column of the data memory.
// Synchronous write, combinational read, whole column cleared by the
// asynchronous reset so the core always starts from zeroed data.
module data_mem_byte_lane
  import data_mem_pkg::*;
#(
  parameter  int MEM_SIZE  = MEM_SIZE_DEFAULT,
  localparam int ADDR_SIZE = $clog2(MEM_SIZE)
) (
  input  logic                  Clk_Core,
  input  logic                  Rst_Core_N,
  input  logic                  wr_en,
  input  logic [ADDR_SIZE-1:0]  word_idx,
  input  logic [LANE_WIDTH-1:0] wr_byte,
  output logic [LANE_WIDTH-1:0] rd_byte
);

  logic [LANE_WIDTH-1:0] mem [MEM_SIZE];

  // Byte write on the rising edge; reset clears every entry immediately.
  always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
    if (!Rst_Core_N) begin
      for (int i = 0; i < MEM_SIZE; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[word_idx] <= wr_byte;
    end
  end

  assign rd_byte = mem[word_idx];

endmodule

// File: rtl/data_mem.sv
// data_mem: word-organised data memory behind the core's load/store path.
// One synchronous byte-enabled write port, one combinational read port
// gated by Read_Ctrl, so a load completes in the same core cycle.
// Optional macro DATA_MEM_RANGE_CHECK_EN: addresses with any bit above the
// memory window set are treated as out of range (writes dropped, reads 0);
// without it those upper bits are ignored and addresses alias.
module data_mem
  import data_mem_pkg::*;
#(
  parameter  int MEM_SIZE  = MEM_SIZE_DEFAULT,
  localparam int ADDR_SIZE = $clog2(MEM_SIZE)
) (
  input logic       Clk_Core,
  input logic       Rst_Core_N,
  data_mem_if.slave mem_bus
);

  logic [ADDR_SIZE-1:0]  word_idx;
  logic                  in_range;
  logic                  unused_addr_bits;
  logic [WORD_WIDTH-1:0] lane_mask;
  logic [WORD_WIDTH-1:0] rd_word;
  logic [WORD_WIDTH-1:0] rd_data;

  // Byte offset bits never select anything; misaligned accesses just use the word.
  assign word_idx = mem_bus.Mem_Data_Address[ADDR_SIZE+1:2];

`ifdef DATA_MEM_RANGE_CHECK_EN
  assign in_range         = ~|mem_bus.Mem_Data_Address[31:ADDR_SIZE+2];
  assign unused_addr_bits = ^mem_bus.Mem_Data_Address[1:0];
`else
  assign in_range         = 1'b1;
  assign unused_addr_bits = ^{mem_bus.Mem_Data_Address[31:ADDR_SIZE+2],
                              mem_bus.Mem_Data_Address[1:0]};
`endif

  assign lane_mask = byte_mask(mem_bus.Write_Ctrl);

  for (genvar j = 0; j < LANE_NUM; j++) begin : g_lane
    data_mem_byte_lane #(
      .MEM_SIZE (MEM_SIZE)
    ) u_lane (
      .Clk_Core   (Clk_Core),
      .Rst_Core_N (Rst_Core_N),
      .wr_en      (in_range & (|lane_mask[j*LANE_WIDTH +: LANE_WIDTH])),
      .word_idx   (word_idx),
      .wr_byte    (mem_bus.Mem_Data_Write[j*LANE_WIDTH +: LANE_WIDTH]),
      .rd_byte    (rd_word[j*LANE_WIDTH +: LANE_WIDTH])
    );
  end

  // Load data only while strobed and in range; otherwise the bus reads zero.
  always_comb begin
    rd_data = '0;
    if (mem_bus.Read_Ctrl && in_range) begin
      rd_data = rd_word;
    end
  end

  assign mem_bus.Mem_Data_Read = rd_data;

endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: directed vector table, multi-cycle corner sequences and a
// randomized regression against a word-array reference model.
module tb_data_mem;

  localparam int MEM_SIZE = 256;

`ifdef DATA_MEM_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  logic Clk_Core   = 1'b0;
  logic Rst_Core_N = 1'b1;

  data_mem_if mem_if ();

  data_mem #(.MEM_SIZE(MEM_SIZE)) dut (
    .Clk_Core   (Clk_Core),
    .Rst_Core_N (Rst_Core_N),
    .mem_bus    (mem_if.slave)
  );

  always #5 Clk_Core = ~Clk_Core;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [MEM_SIZE];

  typedef struct {
    string       name;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wc;
    logic [31:0] rd_addr;
    logic        rc;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] wc);
    @(negedge Clk_Core);
    mem_if.Mem_Data_Address = a;
    mem_if.Mem_Data_Write   = d;
    mem_if.Write_Ctrl       = wc;
    @(posedge Clk_Core);
    #1;
    mem_if.Write_Ctrl = 4'b0000;
  endtask

  task automatic do_read(input logic [31:0] a, input logic rc, output logic [31:0] v);
    mem_if.Mem_Data_Address = a;
    mem_if.Read_Ctrl        = rc;
    #1;
    v = mem_if.Mem_Data_Read;
  endtask

  // Reference: does this byte address reach the array at all?
  function automatic bit addr_ok(input logic [31:0] a);
    return !RANGE_CHECK || (a < 32'(MEM_SIZE * 4));
  endfunction

  function automatic int addr_word(input logic [31:0] a);
    return int'((a / 4) % MEM_SIZE);
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] wc);
    if (addr_ok(a)) begin
      for (int j = 0; j < 4; j++) begin
        if (wc[j]) model[addr_word(a)][j*8 +: 8] = d[j*8 +: 8];
      end
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic rc);
    if (!rc || !addr_ok(a)) return 32'h0;
    return model[addr_word(a)];
  endfunction

  task automatic pulse_reset();
    @(negedge Clk_Core);
    #2 Rst_Core_N = 1'b0;
    #4 Rst_Core_N = 1'b1;
    for (int i = 0; i < MEM_SIZE; i++) model[i] = 32'h0;
  endtask

  logic [31:0] rd;
  logic [31:0] a, d, a2;
  logic [3:0]  wc;
  logic        rc;

  initial begin
    vecs[0]  = '{"rst_rd_000",   32'h0,   32'h0,        4'b0000, 32'h000, 1'b1, 32'h0};
    vecs[1]  = '{"rst_rd_3fc",   32'h0,   32'h0,        4'b0000, 32'h3FC, 1'b1, 32'h0};
    vecs[2]  = '{"full_wr_10",   32'h10,  32'hDEADBEEF, 4'b1111, 32'h10,  1'b1, 32'hDEADBEEF};
    vecs[3]  = '{"rd_gated",     32'h0,   32'h0,        4'b0000, 32'h10,  1'b0, 32'h0};
    vecs[4]  = '{"wc0_no_write", 32'h10,  32'h55555555, 4'b0000, 32'h10,  1'b1, 32'hDEADBEEF};
    vecs[5]  = '{"part_0101",    32'h20,  32'h11223344, 4'b0101, 32'h20,  1'b1, 32'h00220044};
    vecs[6]  = '{"part_1000",    32'h20,  32'hAABBCCDD, 4'b1000, 32'h20,  1'b1, 32'hAA220044};
    vecs[7]  = '{"misalign",     32'h43,  32'hCAFEF00D, 4'b1111, 32'h40,  1'b1, 32'hCAFEF00D};
    vecs[8]  = '{"alias_rd_004", 32'h404, 32'h12345678, 4'b1111, 32'h004, 1'b1,
                 RANGE_CHECK ? 32'h0 : 32'h12345678};
    vecs[9]  = '{"alias_rd_404", 32'h0,   32'h0,        4'b0000, 32'h404, 1'b1,
                 RANGE_CHECK ? 32'h0 : 32'h12345678};
    vecs[10] = '{"neighbour_44", 32'h0,   32'h0,        4'b0000, 32'h44,  1'b1, 32'h0};

    mem_if.Read_Ctrl        = 1'b1;
    mem_if.Write_Ctrl       = 4'b0000;
    mem_if.Mem_Data_Address = 32'h0;
    mem_if.Mem_Data_Write   = 32'h0;
    #1 Rst_Core_N = 1'b0;
    #2;
    check("in_reset_rd", mem_if.Mem_Data_Read, 32'h0);
    repeat (2) @(posedge Clk_Core);
    @(negedge Clk_Core);
    Rst_Core_N = 1'b1;

    // Directed table
    foreach (vecs[i]) begin
      do_write(vecs[i].wr_addr, vecs[i].wr_data, vecs[i].wc);
      do_read(vecs[i].rd_addr, vecs[i].rc, rd);
      check(vecs[i].name, rd, vecs[i].exp);
    end

    // Same-word read during write: old before the edge, new after it
    do_write(32'h80, 32'h01010101, 4'b1111);
    @(negedge Clk_Core);
    mem_if.Read_Ctrl        = 1'b1;
    mem_if.Mem_Data_Address = 32'h80;
    mem_if.Mem_Data_Write   = 32'h02020202;
    mem_if.Write_Ctrl       = 4'b1111;
    #1;
    check("rw_before_edge", mem_if.Mem_Data_Read, 32'h01010101);
    @(posedge Clk_Core);
    #1;
    check("rw_after_edge", mem_if.Mem_Data_Read, 32'h02020202);
    mem_if.Write_Ctrl = 4'b0000;

    // Randomized regression
    pulse_reset();
    for (int it = 0; it < 1000; it++) begin
      a  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h3FF);
      d  = $urandom;
      wc = 4'($urandom_range(0, 15));
      rc = ($urandom_range(0, 7) != 0);
      do_write(a, d, wc);
      model_write(a, d, wc);
      do_read(a, rc, rd);
      check("rand_same", rd, model_read(a, rc));
      a2 = $urandom & 32'h3FF;
      do_read(a2, 1'b1, rd);
      check("rand_other", rd, model_read(a2, 1'b1));
    end

    // Reset asserted mid-cycle with a write pending
    do_write(32'h100, 32'hA5A5A5A5, 4'b1111);
    @(negedge Clk_Core);
    mem_if.Read_Ctrl        = 1'b1;
    mem_if.Mem_Data_Address = 32'h100;
    mem_if.Mem_Data_Write   = 32'h5A5A5A5A;
    mem_if.Write_Ctrl       = 4'b1111;
    #2 Rst_Core_N = 1'b0;
    #1;
    check("rst_async_clear", mem_if.Mem_Data_Read, 32'h0);
    @(posedge Clk_Core);
    #1;
    check("rst_blocks_write", mem_if.Mem_Data_Read, 32'h0);

    // Release: the first rising edge with reset high performs the write
    @(negedge Clk_Core);
    Rst_Core_N              = 1'b1;
    mem_if.Mem_Data_Address = 32'h104;
    mem_if.Mem_Data_Write   = 32'h0BADF00D;
    mem_if.Write_Ctrl       = 4'b1111;
    @(posedge Clk_Core);
    #1;
    mem_if.Write_Ctrl = 4'b0000;
    for (int i = 0; i < MEM_SIZE; i++) begin
      do_read(32'(i * 4), 1'b1, rd);
      check("post_rst_sweep", rd, (i == 16'h41) ? 32'h0BADF00D : 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
